// File: rtl/fb_pkg.sv
// Shared framebuffer-bus definitions used by the fetch and draw clients.
package fb_pkg;
    localparam int unsigned ADDR_W           = 17;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned OP_W             = 4;
    localparam logic [OP_W-1:0] OP_READ      = 4'b0000;
    localparam int unsigned BCAST_FETCH      = 0;
    localparam int unsigned FB_WORDS_DEFAULT = 76800;

    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] last);
        return (addr == last) ? base : addr + 1'b1;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with level output and synchronous flush.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == LVL_W'(DEPTH));
    assign level     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end
endmodule

// File: rtl/pixel_fetcher.sv
// Display read client: credit-limited sequential framebuffer fetch into a FWFT pixel FIFO.
module pixel_fetcher
    import fb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE    = 17'h00000,
    parameter int unsigned       FB_WORDS   = FB_WORDS_DEFAULT,
    parameter int unsigned       FIFO_DEPTH = 16,
    localparam int unsigned      LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              en_fetching,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_wrdata,
    output logic [OP_W-1:0]   fetch_op,
    output logic              fetch_rts,
    input  logic              fetch_rtr,
    input  logic [DATA_W-1:0] bcast_data,
    input  logic [2:0]        bcast_xfc,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              underflow,
    output logic              overflow_err
);
    localparam int unsigned CRED_W = LVL_W + 2;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(32'(FB_BASE) + FB_WORDS - 32'd1);

    logic [ADDR_W-1:0] addr_q;
    logic [LVL_W-1:0]  outstanding_q, discard_q;
    logic              underflow_q, overflow_q;
    logic [CRED_W-1:0] credit_sum;
    logic              credit_ok, accept, ret, drop, push, fifo_empty, fifo_full;
    logic [1:0]        unused_xfc;

    assign unused_xfc = bcast_xfc[2:1];

    // Discarded returns still occupy a FIFO slot's worth of credit until they land.
    assign credit_sum = CRED_W'(fifo_level) + CRED_W'(outstanding_q) + CRED_W'(discard_q);
    assign credit_ok  = credit_sum < CRED_W'(FIFO_DEPTH);

    assign fetch_rts    = en_fetching & credit_ok & ~frame_start;
    assign fetch_addr   = addr_q;
    assign fetch_wrdata = '0;
    assign fetch_op     = OP_READ;

    assign accept = fetch_rts & fetch_rtr;
    assign ret    = bcast_xfc[BCAST_FETCH];
    assign drop   = ret & (discard_q != '0);
    assign push   = ret & (discard_q == '0) & ~frame_start;

    assign pix_valid    = ~fifo_empty;
    assign underflow    = underflow_q;
    assign overflow_err = overflow_q;

    sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst_     (rst_),
        .flush    (frame_start),
        .push     (push),
        .push_data(bcast_data),
        .pop      (pix_ready),
        .head_data(pix_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            addr_q        <= FB_BASE;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else if (frame_start) begin
            // Everything in flight at the restart belongs to the old frame.
            addr_q        <= FB_BASE;
            discard_q     <= discard_q + outstanding_q - LVL_W'(ret);
            outstanding_q <= '0;
        end else begin
            if (accept) addr_q <= addr_next(addr_q, FB_BASE, ADDR_LAST);
            outstanding_q <= outstanding_q + LVL_W'(accept) - LVL_W'(ret & ~drop);
            discard_q     <= discard_q - LVL_W'(drop);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (pix_ready & ~pix_valid & en_fetching) underflow_q <= 1'b1;
            if (push & fifo_full) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_fetcher.sv
// Directed plus randomized checks of pixel_fetcher against a queue-based reference model.
module tb_pixel_fetcher;
    import fb_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_;
    logic        en_fetching, frame_start, fetch_rtr, pix_ready;
    logic [31:0] bcast_data;
    logic [2:0]  bcast_xfc;
    logic [16:0] fetch_addr;
    logic [31:0] fetch_wrdata, pix_data;
    logic [3:0]  fetch_op;
    logic        fetch_rts, pix_valid, underflow, overflow_err;
    logic [4:0]  fifo_level;

    logic [16:0] w5_addr;
    logic [31:0] w5_wrdata, w5_pix_data;
    logic [3:0]  w5_op;
    logic        w5_rts, w5_valid, w5_under, w5_over;
    logic [4:0]  w5_level;

    always #5 clk = ~clk;

    pixel_fetcher dut (
        .clk(clk), .rst_(rst_), .en_fetching(en_fetching), .frame_start(frame_start),
        .fetch_addr(fetch_addr), .fetch_wrdata(fetch_wrdata), .fetch_op(fetch_op),
        .fetch_rts(fetch_rts), .fetch_rtr(fetch_rtr), .bcast_data(bcast_data),
        .bcast_xfc(bcast_xfc), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .fifo_level(fifo_level), .underflow(underflow),
        .overflow_err(overflow_err)
    );

    // Small-frame instance: only its request address sequence is of interest.
    pixel_fetcher #(.FB_WORDS(5)) dut5 (
        .clk(clk), .rst_(rst_), .en_fetching(en_fetching), .frame_start(frame_start),
        .fetch_addr(w5_addr), .fetch_wrdata(w5_wrdata), .fetch_op(w5_op),
        .fetch_rts(w5_rts), .fetch_rtr(fetch_rtr), .bcast_data(32'h0),
        .bcast_xfc(3'b000), .pix_data(w5_pix_data), .pix_valid(w5_valid),
        .pix_ready(1'b0), .fifo_level(w5_level), .underflow(w5_under),
        .overflow_err(w5_over)
    );

    typedef struct {
        logic [16:0] addr;
        int          due;
    } ret_t;

    ret_t        arb_q[$];
    bit          disc_q[$];
    logic [31:0] exp_q[$];
    logic [16:0] m_addr;
    bit          m_under, m_over;
    int          cycle, lat, last_due, dut_acc;
    int          total, bad;

    function automatic logic [31:0] mkword(input logic [16:0] a);
        return {a[14:0], a} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock cycle: inputs already driven at the preceding negedge.
    task automatic step();
        bit          ret, exp_rts, acc, pop, full, f;
        logic [31:0] rdata;
        int          due;
        ret = 1'b0;
        rdata = $urandom;
        if (arb_q.size() > 0 && arb_q[0].due <= cycle) begin
            ret   = 1'b1;
            rdata = mkword(arb_q[0].addr);
            void'(arb_q.pop_front());
        end
        bcast_data = rdata;
        bcast_xfc  = {2'($urandom), ret};
        #1;
        exp_rts = en_fetching && !frame_start && (exp_q.size() + disc_q.size() < DEPTH);
        chk("fetch_rts", 32'(fetch_rts), 32'(exp_rts));
        chk("fetch_addr", 32'(fetch_addr), 32'(m_addr));
        chk("pix_valid", 32'(pix_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("pix_data", pix_data, exp_q[0]);
        chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        chk("underflow", 32'(underflow), 32'(m_under));
        chk("overflow_err", 32'(overflow_err), 32'(m_over));
        chk("fetch_wrdata", fetch_wrdata, 32'h0);
        chk("fetch_op", 32'(fetch_op), 32'h0);
        if (fetch_rts && fetch_rtr) dut_acc++;
        acc  = exp_rts && fetch_rtr;
        pop  = pix_ready && exp_q.size() > 0;
        full = (exp_q.size() == DEPTH);
        @(posedge clk);
        if (pix_ready && exp_q.size() == 0 && en_fetching) m_under = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (ret) begin
            f = 1'b1;
            if (disc_q.size() > 0) f = disc_q.pop_front();
            if (!(frame_start || f)) begin
                if (full) m_over = 1'b1;
                else exp_q.push_back(rdata);
            end
        end
        if (frame_start) begin
            exp_q.delete();
            foreach (disc_q[i]) disc_q[i] = 1'b1;
            m_addr = 17'h0;
        end
        if (acc) begin
            disc_q.push_back(1'b0);
            due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
            arb_q.push_back('{addr: m_addr, due: due});
            last_due = due;
            m_addr = (m_addr == 17'(FB_WORDS_DEFAULT - 1)) ? 17'h0 : m_addr + 17'h1;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic en, input logic rtr, input logic rdy);
        en_fetching = en;
        fetch_rtr   = rtr;
        pix_ready   = rdy;
        frame_start = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cycle = 0; last_due = -1; dut_acc = 0; lat = 3;
        m_addr = 17'h0; m_under = 1'b0; m_over = 1'b0;
        rst_ = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        bcast_data = 32'h0; bcast_xfc = 3'b000;
        #12;
        chk("rst_rts", 32'(fetch_rts), 32'h0);
        chk("rst_addr", 32'(fetch_addr), 32'h0);
        chk("rst_wrdata", fetch_wrdata, 32'h0);
        chk("rst_op", 32'(fetch_op), 32'h0);
        chk("rst_valid", 32'(pix_valid), 32'h0);
        chk("rst_pix_data", pix_data, 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
        chk("rst_overflow", 32'(overflow_err), 32'h0);
        chk("rst_w5", {w5_wrdata ^ w5_pix_data, 8'(w5_op), 8'(w5_level),
                       4'({w5_valid, w5_under, w5_over}), 4'(w5_addr)}, 32'h0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);

        // Fill with no consumer; the small-frame instance must wrap 0..4,0,1.
        drive(1'b1, 1'b1, 1'b0);
        lat = 3; dut_acc = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("wrap_rts", 32'(w5_rts), 32'h1);
            chk("wrap_addr", 32'(w5_addr), 32'(i % 5));
            step();
        end
        run(17);
        chk("fill_accepts", 32'(dut_acc), 32'd16);
        chk("fill_level", 32'(fifo_level), 32'd16);
        chk("fill_rts_off", 32'(fetch_rts), 32'h0);
        chk("fill_overflow", 32'(overflow_err), 32'h0);

        // Continuous drain with continuous issue.
        drive(1'b1, 1'b1, 1'b1);
        run(40);
        drive(1'b0, 1'b1, 1'b1);
        run(20);

        // Restart with data buffered and four requests in flight.
        drive(1'b1, 1'b1, 1'b0);
        lat = 2; run(3);
        lat = 8; run(4);
        chk("restart_pre_level", 32'(fifo_level), 32'd3);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("restart_flushed", 32'(fifo_level), 32'h0);
        for (int i = 0; i < 30 && !pix_valid; i++) step();
        chk("restart_valid", 32'(pix_valid), 32'h1);
        chk("restart_first_word", pix_data, mkword(17'h0));
        drive(1'b0, 1'b1, 1'b1);
        run(25);

        // Issue disabled with three in flight, then underflow qualification.
        drive(1'b1, 1'b1, 1'b0);
        lat = 5; dut_acc = 0;
        run(3);
        drive(1'b0, 1'b1, 1'b0);
        run(10);
        chk("disable_accepts", 32'(dut_acc), 32'd3);
        chk("disable_level", 32'(fifo_level), 32'd3);
        drive(1'b0, 1'b1, 1'b1);
        run(8);
        chk("underflow_gated", 32'(underflow), 32'h0);
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk("underflow_set", 32'(underflow), 32'h1);

        // Near-full operation with single-cycle round trip.
        drive(1'b1, 1'b1, 1'b0);
        lat = 1; run(20);
        drive(1'b1, 1'b1, 1'b1);
        run(15);
        chk("nearfull_overflow", 32'(overflow_err), 32'h0);

        // Randomized traffic, latency and restarts.
        for (int i = 0; i < 400; i++) begin
            en_fetching = ($urandom_range(0, 9) != 0);
            frame_start = ($urandom_range(0, 39) == 0);
            fetch_rtr   = ($urandom_range(0, 3) != 0);
            pix_ready   = ($urandom_range(0, 2) != 0);
            lat         = int'($urandom_range(1, 8));
            step();
        end
        frame_start = 1'b0;
        chk("random_overflow", 32'(overflow_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
